// File: rtl/branch_predictor.sv
// Fetch-side dynamic branch predictor: direct-mapped table of tagged 2-bit
// saturating counters with targets, plus EX-stage resolve and perf counters.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [1:0]          ctr;
    logic [31:0]         target;
  } entry_t;

  entry_t table_q [ENTRIES];

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  entry_t              if_entry, ex_entry;
  logic                if_hit, ex_hit;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Lookup reads the registered table only, so a same-cycle update is not seen.
  always_comb begin
    if_entry    = table_q[if_idx];
    if_hit      = if_entry.valid && (if_entry.tag == if_tag);
    pred_taken  = if_hit && if_entry.ctr[1];
    pred_target = pred_taken ? if_entry.target : if_pc + 32'd4;
  end

  always_comb begin
    ex_entry    = table_q[ex_idx];
    ex_hit      = ex_entry.valid && (ex_entry.tag == ex_tag);
    mispredict  = ex_is_branch &&
                  ((ex_pred_taken != ex_taken) ||
                   (ex_taken && (ex_pred_target != ex_target)));
    redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
  end

  // NOTE: the table is reset entry by entry because the lookup must miss for
  // every PC immediately after reset; this forces flops rather than a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, ctr: 2'b01, target: 32'd0};
      end
    end else if (ex_is_branch) begin
      if (ex_hit) begin
        // NOTE: non-blocking assignments keep every read in this block seeing
        // pre-edge state, matching the combinational lookup above.
        if (ex_taken) begin
          if (ex_entry.ctr != 2'b11) table_q[ex_idx].ctr <= ex_entry.ctr + 2'd1;
          table_q[ex_idx].target <= ex_target;
        end else if (ex_entry.ctr != 2'b00) begin
          table_q[ex_idx].ctr <= ex_entry.ctr - 2'd1;
        end
      end else begin
        table_q[ex_idx] <= '{valid:  1'b1,
                             tag:    ex_tag,
                             ctr:    ex_taken ? 2'b10 : 2'b01,
                             target: ex_target};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      if (ex_is_branch && (branch_count != 32'hFFFF_FFFF))
        branch_count <= branch_count + 32'd1;
      if (mispredict && (mispredict_count != 32'hFFFF_FFFF))
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: expectations are queued as
// stimulus is driven and popped against the DUT outputs once they settle.
module tb_branch_predictor;

  // A wider tag makes 0x0040_0020 and 0x0041_0020 distinct tags at one index.
  localparam int IDX_BITS = 6;
  localparam int TAG_BITS = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_pc = 32'd0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_is_branch = 1'b0;
  logic [31:0] ex_pc = 32'd0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = 32'd0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = 32'd0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predictor #(.IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_is_branch     (ex_is_branch),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef enum {S_PT, S_PTG, S_MP, S_RPC, S_BC, S_MC} sel_e;
  typedef struct {
    sel_e        sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic expect_val(input sel_e s, input logic [31:0] v, input string n);
    sb.push_back('{sel: s, val: v, name: n});
  endtask

  function automatic logic [31:0] observe(input sel_e s);
    case (s)
      S_PT:    return {31'd0, pred_taken};
      S_PTG:   return pred_target;
      S_MP:    return {31'd0, mispredict};
      S_RPC:   return redirect_pc;
      S_BC:    return branch_count;
      default: return mispredict_count;
    endcase
  endfunction

  task automatic check();
    exp_t        e;
    logic [31:0] observed;
    while (sb.size() > 0) begin
      e        = sb.pop_front();
      observed = observe(e.sel);
      compared++;
      assert (observed === e.val) else begin
        mismatched++;
        $error("FAIL %s: observed=%h expected=%h", e.name, observed, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    ex_is_branch   = 1'b1;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic idle();
    ex_is_branch = 1'b0;
  endtask

  localparam logic [31:0] PC_A  = 32'h0040_0020;
  localparam logic [31:0] PC_B  = 32'h0041_0020;
  localparam logic [31:0] TGT_A = 32'h0040_0100;

  initial begin
    // Reset state, released between edges.
    #12 reset = 1'b0;
    if_pc = 32'h0040_0010;
    #1;
    expect_val(S_PT,  32'd0,           "reset_pt");
    expect_val(S_PTG, 32'h0040_0014,   "reset_ptg");
    expect_val(S_BC,  32'd0,           "reset_bc");
    expect_val(S_MC,  32'd0,           "reset_mc");
    expect_val(S_MP,  32'd0,           "reset_mp");
    check();
    if_pc = 32'hFFFF_FFFC;
    #1;
    expect_val(S_PTG, 32'd0,           "wrap_ptg");
    check();

    // Cold miss on a taken branch, then learned.
    tick();
    resolve(PC_A, 1'b1, TGT_A, 1'b0, PC_A + 32'd4);
    if_pc = PC_A;
    #1;
    expect_val(S_MP,  32'd1,  "cold_mp");
    expect_val(S_RPC, TGT_A,  "cold_rpc");
    expect_val(S_PT,  32'd0,  "cold_pt_same_cycle");
    check();
    tick();
    idle();
    #1;
    expect_val(S_PT,  32'd1,  "learn_pt");
    expect_val(S_PTG, TGT_A,  "learn_ptg");
    expect_val(S_BC,  32'd1,  "learn_bc");
    expect_val(S_MC,  32'd1,  "learn_mc");
    check();

    // Four correctly predicted taken resolutions saturate the counter at 11.
    for (int i = 0; i < 4; i++) begin
      resolve(PC_A, 1'b1, TGT_A, 1'b1, TGT_A);
      #1;
      expect_val(S_MP, 32'd0, "sat_mp");
      check();
      tick();
    end
    idle();
    #1;
    expect_val(S_BC, 32'd5, "sat_bc");
    expect_val(S_MC, 32'd1, "sat_mc");
    check();

    // Hysteresis: first not-taken keeps predicting taken, second flips it.
    resolve(PC_A, 1'b0, TGT_A, 1'b1, TGT_A);
    #1;
    expect_val(S_MP,  32'd1,         "nt1_mp");
    expect_val(S_RPC, PC_A + 32'd4,  "nt1_rpc");
    check();
    tick();
    idle();
    #1;
    expect_val(S_PT,  32'd1,  "nt1_pt");
    expect_val(S_PTG, TGT_A,  "nt1_ptg");
    check();
    resolve(PC_A, 1'b0, TGT_A, 1'b1, TGT_A);
    tick();
    idle();
    #1;
    expect_val(S_PT,  32'd0,         "nt2_pt");
    expect_val(S_PTG, PC_A + 32'd4,  "nt2_ptg");
    expect_val(S_BC,  32'd7,         "nt2_bc");
    expect_val(S_MC,  32'd3,         "nt2_mc");
    check();

    // Aliasing: retrain A taken, then allocate B over the same index.
    resolve(PC_A, 1'b1, TGT_A, 1'b0, PC_A + 32'd4);
    tick();
    idle();
    #1;
    expect_val(S_PT, 32'd1, "alias_train_pt");
    check();
    resolve(PC_B, 1'b0, 32'h0041_0200, 1'b0, PC_B + 32'd4);
    #1;
    expect_val(S_MP,  32'd0,         "alias_b_mp");
    expect_val(S_RPC, PC_B + 32'd4,  "alias_b_rpc");
    check();
    tick();
    idle();
    #1;
    expect_val(S_PT,  32'd0,         "alias_a_miss_pt");
    expect_val(S_PTG, PC_A + 32'd4,  "alias_a_miss_ptg");
    check();

    // Same-index collision: B is at ctr 01; lookup and taken update together.
    if_pc = PC_B;
    resolve(PC_B, 1'b1, 32'h0041_0200, 1'b0, PC_B + 32'd4);
    #1;
    expect_val(S_PT, 32'd0, "collide_pt_now");
    expect_val(S_MP, 32'd1, "collide_mp");
    check();
    tick();
    idle();
    #1;
    expect_val(S_PT,  32'd1,          "collide_pt_next");
    expect_val(S_PTG, 32'h0041_0200,  "collide_ptg_next");
    expect_val(S_BC,  32'd10,         "collide_bc");
    expect_val(S_MC,  32'd5,          "collide_mc");
    check();

    // Target mismatch with correct direction.
    resolve(PC_B, 1'b1, 32'h0041_0300, 1'b1, 32'h0041_0200);
    #1;
    expect_val(S_MP,  32'd1,          "tgt_mp");
    expect_val(S_RPC, 32'h0041_0300,  "tgt_rpc");
    check();
    tick();
    idle();
    #1;
    expect_val(S_MC,  32'd6,          "tgt_mc");
    expect_val(S_BC,  32'd11,         "tgt_bc");
    expect_val(S_PTG, 32'h0041_0300,  "tgt_ptg");
    check();

    // Asynchronous reset between edges, then held across an update edge.
    reset = 1'b1;
    #1;
    expect_val(S_BC,  32'd0,         "arst_bc");
    expect_val(S_MC,  32'd0,         "arst_mc");
    expect_val(S_PT,  32'd0,         "arst_pt_b");
    expect_val(S_PTG, PC_B + 32'd4,  "arst_ptg_b");
    check();
    if_pc = 32'h0040_0010;
    #1;
    expect_val(S_PT, 32'd0, "arst_pt_other");
    check();
    resolve(PC_B, 1'b1, 32'h0041_0300, 1'b0, PC_B + 32'd4);
    if_pc = PC_B;
    tick();
    idle();
    #1;
    expect_val(S_BC, 32'd0, "arst_hold_bc");
    expect_val(S_MC, 32'd0, "arst_hold_mc");
    expect_val(S_PT, 32'd0, "arst_hold_pt");
    check();
    reset = 1'b0;
    #1;
    expect_val(S_MP, 32'd0, "post_reset_mp");
    expect_val(S_PT, 32'd0, "post_reset_pt");
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
